// File: rtl/mul_seq_arbiter.sv
// -----------------------------------------------------------------------------
// mul_seq_arbiter
//
// Shared-multiplier controller. Two requesters submit 8x8 multiply jobs over
// valid/ready handshakes; a round-robin arbiter grants one job at a time. The
// job is multiplied by one internal 4x4 add-tree multiplier over four
// partial-product cycles, accumulating into a 16-bit result.
//
// Handshake rule (all channels): a transfer happens on the rising clk edge
// where valid and ready are both high. Requesters hold operands and valid
// stable until ready; the consumer sees res_valid/res_data/res_id held stable
// until res_ready.
//
// Optional feature: define MULSEQ_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied, the sign is applied when the result is shown).
// Without the macro, operands are unsigned and no sign logic exists.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous reset, ACTIVE-HIGH (1 = reset)
//   r0_valid/r0_ready   requester 0 job handshake
//   r0_a, r0_b          requester 0 operands (8 bit)
//   r1_valid/r1_ready   requester 1 job handshake
//   r1_a, r1_b          requester 1 operands (8 bit)
//   res_valid/res_ready result handshake
//   res_data            16-bit product
//   res_id              requester that issued the result
//   busy                high in any state except IDLE
//   dbg_state           current FSM state (0 IDLE, 1 MUL, 2 DONE)
// -----------------------------------------------------------------------------
module mul_seq_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [7:0]  r0_a,
    input  logic [7:0]  r0_b,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [7:0]  r1_a,
    input  logic [7:0]  r1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_phase;
    logic [15:0] r_acc;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_id;
    logic        r_last;     // requester served last; loses the next tie

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic [7:0]  w_sel_a;
    logic [7:0]  w_sel_b;
    logic [7:0]  w_load_a;
    logic [7:0]  w_load_b;
    logic [3:0]  w_nib_a;
    logic [3:0]  w_nib_b;
    logic [7:0]  w_row [4];
    logic [7:0]  w_pp;
    logic [15:0] w_pp_shift;
    logic [15:0] w_result;

`ifdef MULSEQ_SIGNED_EN
    logic        r_sign;
`endif

    // ------------------------------------------------------------------
    // Arbitration: only in IDLE and never while reset is asserted.
    // On a tie, the requester not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE && !rst_n) begin
            if (r0_valid && r1_valid) begin
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
            end else begin
                w_gnt0 = r0_valid;
                w_gnt1 = r1_valid;
            end
        end
    end

    assign w_accept = w_gnt0 | w_gnt1;
    assign w_sel_a  = w_gnt1 ? r1_a : r0_a;
    assign w_sel_b  = w_gnt1 ? r1_b : r0_b;

`ifdef MULSEQ_SIGNED_EN
    // Magnitude of an 8-bit two's-complement value; -128 maps to 8'h80,
    // which is 128 when read as unsigned.
    assign w_load_a = w_sel_a[7] ? (~w_sel_a + 8'd1) : w_sel_a;
    assign w_load_b = w_sel_b[7] ? (~w_sel_b + 8'd1) : w_sel_b;
    assign w_result = r_sign ? (~r_acc + 16'd1) : r_acc;
`else
    assign w_load_a = w_sel_a;
    assign w_load_b = w_sel_b;
    assign w_result = r_acc;
`endif

    // ------------------------------------------------------------------
    // Nibble selection per phase:
    //   0: aL*bL<<0   1: aL*bH<<4   2: aH*bL<<4   3: aH*bH<<8
    // ------------------------------------------------------------------
    always_comb begin
        w_nib_a = r_phase[1] ? r_a[7:4] : r_a[3:0];
        w_nib_b = r_phase[0] ? r_b[7:4] : r_b[3:0];
    end

    // 4x4 add-tree: four shifted partial rows summed pairwise.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_row[i] = w_nib_b[i] ? ({4'b0000, w_nib_a} << i) : 8'd0;
        end
        w_pp = (w_row[0] + w_row[1]) + (w_row[2] + w_row[3]);
    end

    always_comb begin
        case (r_phase)
            2'd0:    w_pp_shift = {8'd0, w_pp};
            2'd3:    w_pp_shift = {w_pp, 8'd0};
            default: w_pp_shift = {4'd0, w_pp, 4'd0};
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)          w_next = S_MUL;
            S_MUL:   if (r_phase == 2'd3)   w_next = S_DONE;
            S_DONE:  if (res_ready)         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        r0_ready  = w_gnt0;
        r1_ready  = w_gnt1;
        busy      = (r_state != S_IDLE);
        res_valid = (r_state == S_DONE);
        res_data  = (r_state == S_DONE) ? w_result : 16'd0;
        res_id    = (r_state == S_DONE) ? r_id : 1'b0;
        dbg_state = r_state;
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, phase counter, accumulator, pointer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_phase <= 2'd0;
            r_acc   <= 16'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_accept) begin
            r_phase <= 2'd0;
            r_acc   <= 16'd0;
            r_a     <= w_load_a;
            r_b     <= w_load_b;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
        end else if (r_state == S_MUL) begin
            r_acc   <= r_acc + w_pp_shift;
            r_phase <= r_phase + 2'd1;
        end
    end

`ifdef MULSEQ_SIGNED_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_sign <= w_sel_a[7] ^ w_sel_b[7];
        end
    end
`endif

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_arbiter
//
// Self-checking bench for mul_seq_arbiter. A cycle-level reference model
// (job queues per requester, a countdown to the result, a last-served flag)
// predicts ready, busy and result values every cycle; results are checked
// through an expected queue holding {id, product}.
// -----------------------------------------------------------------------------
module tb_mul_seq_arbiter;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [7:0]  r0_a, r0_b, r1_a, r1_b;
    logic        res_valid, res_ready, res_id, busy;
    logic [15:0] res_data;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    mul_seq_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [16:0] exp_q[$];           // {id, product}
    logic [31:0] job0_q[$];          // {expected product, a, b}
    logic [31:0] job1_q[$];
    bit          pres0, pres1;       // requester currently presenting its head job
    bit          eager;              // present jobs immediately
    bit          pulse1_en;          // allow stray r1 pulses while busy
    int          rr_mode;            // 0: res_ready=1, 1: random, 2: res_ready=0

    bit          m_busy, m_done, m_last;
    int          m_wait;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
        int x, y;
`ifdef MULSEQ_SIGNED_EN
        x = $signed(a);
        y = $signed(b);
`else
        x = int'(a);
        y = int'(b);
`endif
        model_mul = 16'(x * y);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic submit(input bit who, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        if (who) job1_q.push_back({p, a, b});
        else     job0_q.push_back({p, a, b});
    endtask

    // One clock cycle: drive, check against model, advance model, step clock.
    // Entered and left just after a rising edge.
    task automatic run_cycle(input bit do_rst);
        bit          idle, pulse, exp_r0, exp_r1;
        logic [31:0] j;
        rst_n = do_rst;
        if (!pres0 && job0_q.size() > 0 && (eager || $urandom_range(0, 1) == 1)) pres0 = 1'b1;
        if (!pres1 && job1_q.size() > 0 && (eager || $urandom_range(0, 1) == 1)) pres1 = 1'b1;
        pulse = !pres1 && pulse1_en && (m_busy || m_done) && ($urandom_range(0, 2) == 0);
        r0_valid = pres0;
        r0_a     = pres0 ? job0_q[0][15:8] : 8'($urandom);
        r0_b     = pres0 ? job0_q[0][7:0]  : 8'($urandom);
        r1_valid = pres1 || pulse;
        r1_a     = pres1 ? job1_q[0][15:8] : 8'($urandom);
        r1_b     = pres1 ? job1_q[0][7:0]  : 8'($urandom);
        case (rr_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom_range(0, 2) != 0);
            default: res_ready = 1'b0;
        endcase
        #1;
        idle   = !m_busy && !m_done && !do_rst;
        exp_r0 = idle && pres0 && (!pres1 || m_last);
        exp_r1 = idle && pres1 && (!pres0 || !m_last);
        check_eq("r0_ready", r0_ready, exp_r0);
        check_eq("r1_ready", r1_ready, exp_r1);
        check_eq("ready_onehot", r0_ready & r1_ready, 0);
        check_eq("busy", busy, m_busy || m_done);
        check_eq("res_valid", res_valid, m_done);
        if (m_done && exp_q.size() > 0) begin
            check_eq("res_data", res_data, exp_q[0][15:0]);
            check_eq("res_id", res_id, exp_q[0][16]);
        end
        // advance the model over the coming edge
        if (do_rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_last = 1'b1;
            exp_q.delete();
        end else if (exp_r0 || exp_r1) begin
            j = exp_r0 ? job0_q.pop_front() : job1_q.pop_front();
            exp_q.push_back({exp_r1, j[31:16]});
            m_last = exp_r1;
            m_busy = 1'b1;
            m_wait = 4;
            if (exp_r0) pres0 = 1'b0;
            else        pres1 = 1'b0;
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_done && res_ready) begin
            m_done = 1'b0;
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((job0_q.size() + job1_q.size() + exp_q.size()) > 0 || m_busy || m_done) begin
            if (n >= budget) begin
                check_eq("drain_timeout", job0_q.size() + job1_q.size() + exp_q.size(), 0);
                break;
            end
            run_cycle(1'b0);
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] a, b;
        rst_n     = 1'b1;
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
        r0_a = 8'd0; r0_b = 8'd0; r1_a = 8'd0; r1_b = 8'd0;
        res_ready = 1'b0;
        pres0 = 0; pres1 = 0; eager = 1; pulse1_en = 0; rr_mode = 0;

        repeat (2) @(posedge clk);
        #1;
        // reset values, with both valids high while reset is held
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_id", res_id, 0);
        check_eq("rst_r0_ready", r0_ready, 0);
        check_eq("rst_r1_ready", r1_ready, 0);
        m_busy = 0; m_done = 0; m_last = 1; m_wait = 0;
        run_cycle(1'b1);

        // idle stability
        repeat (20) run_cycle(1'b0);

        // single jobs with fixed expected products
`ifdef MULSEQ_SIGNED_EN
        submit(0, 8'hFD, 8'd5,   16'hFFF1);
        submit(0, 8'h80, 8'h80,  16'h4000);
        submit(0, 8'd127, 8'hFF, 16'hFF81);
`else
        submit(0, 8'd200, 8'd150, 16'h7530);
        submit(0, 8'd255, 8'd255, 16'hFE01);
        submit(0, 8'd0,   8'd77,  16'h0000);
`endif
        drain(100);

        // tie and fairness: both present continuously
        submit(0, 8'd3, 8'd4, 16'd12);
        submit(1, 8'd5, 8'd6, 16'd30);
        submit(0, 8'd3, 8'd4, 16'd12);
        submit(1, 8'd5, 8'd6, 16'd30);
        drain(100);

        // back-pressure: hold res_ready low in DONE, r1 waiting meanwhile
        submit(0, 8'd9, 8'd7, 16'd63);
        run_cycle(1'b0);
        submit(1, 8'd2, 8'd3, 16'd6);
        rr_mode = 2;
        repeat (8) run_cycle(1'b0);
        rr_mode = 0;
        drain(100);

        // reset during MUL phase 2, then a tie that r0 must win
        submit(0, 8'd10, 8'd20, 16'd200);
        run_cycle(1'b0);                 // accept
        submit(0, 8'd3, 8'd4, 16'd12);
        submit(1, 8'd5, 8'd6, 16'd30);
        run_cycle(1'b0);                 // phase 0
        run_cycle(1'b0);                 // phase 1
        run_cycle(1'b1);                 // phase 2 with reset
        drain(100);

        // randomized traffic with back-pressure and stray r1 pulses
        eager = 0; pulse1_en = 1; rr_mode = 1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                2:       a = 8'h80;
                default: a = 8'($urandom);
            endcase
            b = 8'($urandom);
            submit(1'($urandom_range(0, 1)), a, b, model_mul(a, b));
        end
        drain(3000);
        pulse1_en = 0; rr_mode = 0;
        repeat (5) run_cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
